// File: rtl/gates_sweep_checker_if.sv
// Bundles the run handshake, the operand drive, the eight gate results and the
// pass/fail report exchanged between the sweep checker and its surroundings.
interface gates_sweep_checker_if;
  logic       start;
  logic       a_o;
  logic       b_o;
  logic       an_d;
  logic       o_r;
  logic       no_t;
  logic       no_t_b;
  logic       xo_r;
  logic       na_nd;
  logic       no_r;
  logic       xn_or;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] fail_mask;

  // The master side requests runs and returns the gate results.
  modport master (
    output start,
    output an_d, o_r, no_t, no_t_b, xo_r, na_nd, no_r, xn_or,
    input  a_o, b_o,
    input  busy, done, pass, err_count, fail_mask
  );

  modport slave (
    input  start,
    input  an_d, o_r, no_t, no_t_b, xo_r, na_nd, no_r, xn_or,
    output a_o, b_o,
    output busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/gates_sweep_checker.sv
// Sweeps the two operands of a combinational gate block through 00,01,10,11,
// waits a settle time per vector and checks all eight results against their truth tables.
module gates_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned REPEATS       = 1
) (
  input logic clk,
  input logic rst,
  gates_sweep_checker_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SWEEP_LAST  = 8'(REPEATS - 1);

  logic [1:0] state;
  logic [7:0] settle_cnt;
  logic [7:0] sweep_cnt;
  logic [1:0] step;
  logic       a_q;
  logic       b_q;
  logic       pass_q;
  logic [7:0] err_q;
  logic [7:0] mask_q;

  logic [7:0] expected;
  logic [7:0] actual;
  logic [7:0] mismatch;
  logic [7:0] err_next;
  logic       last_vector;

  // Expected results come from the operands currently driven, so the compare
  // needs no registered copy of the gate outputs.
  always_comb begin
    expected = {a_q & b_q, a_q | b_q, ~a_q, ~b_q,
                a_q ^ b_q, ~(a_q & b_q), ~(a_q | b_q), ~(a_q ^ b_q)};
    actual   = {bus.an_d, bus.o_r, bus.no_t, bus.no_t_b,
                bus.xo_r, bus.na_nd, bus.no_r, bus.xn_or};
    mismatch = expected ^ actual;
    err_next = err_q;
    if ((|mismatch) && (err_q != 8'hFF)) begin
      err_next = err_q + 8'd1;
    end
    last_vector = (step == 2'd3) && (sweep_cnt == SWEEP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      sweep_cnt  <= 8'd0;
      step       <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 8'd0;
      mask_q     <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= SETTLE;
            settle_cnt <= 8'd0;
            sweep_cnt  <= 8'd0;
            step       <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 8'd0;
            mask_q     <= 8'd0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          mask_q <= mask_q | mismatch;
          err_q  <= err_next;
          if (last_vector) begin
            state  <= DONE;
            pass_q <= (err_next == 8'd0);
          end else begin
            // Step wraps 3->0 naturally; the next vector is simply step+1.
            step       <= step + 2'd1;
            {a_q, b_q} <= step + 2'd1;
            if (step == 2'd3) begin
              sweep_cnt <= sweep_cnt + 8'd1;
            end
            settle_cnt <= 8'd0;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.busy      = (state == SETTLE) || (state == CHECK);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gates_sweep_checker.sv
// Bench for gates_sweep_checker: a faultable gate-block model feeds two checker
// instances, whose run trajectories are compared with a per-vector reference model.
module tb_gates_sweep_checker;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_req;
  logic            use2;
  logic [2:0]      fault;
  logic [3:0][7:0] flips;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gates_sweep_checker_if bus1();
  gates_sweep_checker_if bus2();

  gates_sweep_checker #(.SETTLE_CYCLES(1), .REPEATS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  gates_sweep_checker #(.SETTLE_CYCLES(3), .REPEATS(100)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Truth tables, bit order an_d,o_r,no_t,no_t_b,xo_r,na_nd,no_r,xn_or.
  function automatic logic [7:0] ideal_gates(input logic a, input logic b);
    return {a & b, a | b, ~a, ~b, a ^ b, ~(a & b), ~(a | b), ~(a ^ b)};
  endfunction

  // fault bit0: xo_r stuck 0, bit1: no_t/no_t_b swapped, bit2: an_d stuck 1.
  function automatic logic [7:0] gate_model(input logic a, input logic b,
                                            input logic [2:0] f,
                                            input logic [3:0][7:0] fl);
    logic [7:0] g;
    g = ideal_gates(a, b);
    if (f[0]) g[3] = 1'b0;
    if (f[1]) begin
      g[5] = ~b;
      g[4] = ~a;
    end
    if (f[2]) g[7] = 1'b1;
    return g ^ fl[{a, b}];
  endfunction

  logic [7:0] g1, g2;
  assign g1 = gate_model(bus1.a_o, bus1.b_o, fault, flips);
  assign g2 = gate_model(bus2.a_o, bus2.b_o, fault, flips);
  assign {bus1.an_d, bus1.o_r, bus1.no_t, bus1.no_t_b,
          bus1.xo_r, bus1.na_nd, bus1.no_r, bus1.xn_or} = g1;
  assign {bus2.an_d, bus2.o_r, bus2.no_t, bus2.no_t_b,
          bus2.xo_r, bus2.na_nd, bus2.no_r, bus2.xn_or} = g2;
  assign bus1.start = start_req & ~use2;
  assign bus2.start = start_req & use2;

  logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
  logic [7:0] obs_err, obs_mask;
  assign obs_a    = use2 ? bus2.a_o       : bus1.a_o;
  assign obs_b    = use2 ? bus2.b_o       : bus1.b_o;
  assign obs_busy = use2 ? bus2.busy      : bus1.busy;
  assign obs_done = use2 ? bus2.done      : bus1.done;
  assign obs_pass = use2 ? bus2.pass      : bus1.pass;
  assign obs_err  = use2 ? bus2.err_count : bus1.err_count;
  assign obs_mask = use2 ? bus2.fail_mask : bus1.fail_mask;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " ab"},        int'({obs_a, obs_b}), 0);
    checkOutput({tag, " busy"},      int'(obs_busy), 0);
    checkOutput({tag, " done"},      int'(obs_done), 0);
    checkOutput({tag, " pass"},      int'(obs_pass), 0);
    checkOutput({tag, " err_count"}, int'(obs_err), 0);
    checkOutput({tag, " fail_mask"}, int'(obs_mask), 0);
  endtask

  // Runs one sweep and compares every cycle against the reference: vector v of
  // global index g is driven during samples [g*(s+1), (g+1)*(s+1)) and its result
  // is visible from sample (g+1)*(s+1); done appears at sample 4*r*(s+1).
  task automatic applyStimulus(input logic sel, input int s, input int r,
                               input int inject_at, input string tag,
                               output int err_exp, output int mask_exp);
    int         total;
    int         bad;
    int         g;
    logic [7:0] diff [4];
    logic [1:0] exp_ab;
    logic [1:0] vv;
    total    = 4 * r * (s + 1);
    bad      = 0;
    err_exp  = 0;
    mask_exp = 0;
    for (int v = 0; v < 4; v++) begin
      vv      = 2'(v);
      diff[v] = gate_model(vv[1], vv[0], fault, flips) ^ ideal_gates(vv[1], vv[0]);
    end
    use2 = sel;
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    for (int i = 0; i <= total; i++) begin
      if (i > 0 && (i % (s + 1)) == 0) begin
        g = i / (s + 1) - 1;
        if (diff[g % 4] != 8'h00 && err_exp < 255) err_exp++;
        mask_exp = mask_exp | int'(diff[g % 4]);
      end
      exp_ab = (i < total) ? 2'((i / (s + 1)) % 4) : 2'b11;
      if ({obs_a, obs_b} !== exp_ab || obs_busy !== (i < total) ||
          obs_done !== (i == total) || int'(obs_err) !== err_exp ||
          int'(obs_mask) !== mask_exp) begin
        bad++;
      end
      start_req = (i == inject_at);
      if (i < total) @(negedge clk);
    end
    start_req = 1'b0;
    checkOutput({tag, " trajectory_bad_samples"}, bad, 0);
    checkOutput({tag, " done_at_end"}, int'(obs_done), 1);
    checkOutput({tag, " pass_model"}, int'(obs_pass), int'(err_exp == 0));
  endtask

  typedef struct {
    logic       sel;
    int         s;
    int         r;
    logic [2:0] fault;
    int         inject_at;
    int         exp_err;
    int         exp_mask;
    int         exp_pass;
    string      name;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e_exp, m_exp;
    tbl[0] = '{1'b0, 1, 1,   3'b001, -1, 2,   8'h08, 0, "xor_stuck0"};
    tbl[1] = '{1'b0, 1, 1,   3'b010,  3, 2,   8'h30, 0, "not_swapped_overlap_start"};
    tbl[2] = '{1'b0, 1, 1,   3'b101, -1, 3,   8'h88, 0, "xor0_and1"};
    tbl[3] = '{1'b0, 1, 1,   3'b000, -1, 0,   8'h00, 1, "clean_restart"};
    tbl[4] = '{1'b1, 3, 100, 3'b100, -1, 255, 8'h80, 0, "and_stuck1_saturate"};

    rst = 1'b1;
    start_req = 1'b0;
    use2 = 1'b0;
    fault = 3'b000;
    flips = '0;
    repeat (2) @(negedge clk);
    checkCleared("reset dut1");
    use2 = 1'b1;
    #1;
    checkCleared("reset dut2");
    use2 = 1'b0;
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      fault = tbl[k].fault;
      flips = '0;
      applyStimulus(tbl[k].sel, tbl[k].s, tbl[k].r, tbl[k].inject_at, tbl[k].name,
                    e_exp, m_exp);
      checkOutput({tbl[k].name, " err_count"}, int'(obs_err),  tbl[k].exp_err);
      checkOutput({tbl[k].name, " fail_mask"}, int'(obs_mask), tbl[k].exp_mask);
      checkOutput({tbl[k].name, " pass"},      int'(obs_pass), tbl[k].exp_pass);
    end

    // DONE holds its results and operands while start stays low.
    use2 = 1'b0;
    fault = 3'b001;
    applyStimulus(1'b0, 1, 1, -1, "hold_run", e_exp, m_exp);
    repeat (3) @(negedge clk);
    checkOutput("hold done", int'(obs_done), 1);
    checkOutput("hold ab", int'({obs_a, obs_b}), 3);
    checkOutput("hold err_count", int'(obs_err), 2);

    // Reset during the third vector's settle phase returns everything to idle.
    fault = 3'b000;
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrun ab before reset", int'({obs_a, obs_b}), 2);
    checkOutput("midrun busy before reset", int'(obs_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    checkCleared("midrun reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle after reset busy", int'(obs_busy), 0);

    // Random per-vector corruption checked against the reference model.
    for (int k = 0; k < 6; k++) begin
      fault = 3'b000;
      for (int v = 0; v < 4; v++) begin
        flips[v] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      end
      applyStimulus(k == 5, (k == 5) ? 3 : 1, (k == 5) ? 100 : 1, -1, "random",
                    e_exp, m_exp);
      checkOutput("random err_count", int'(obs_err),  e_exp);
      checkOutput("random fail_mask", int'(obs_mask), m_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
